// File: rtl/conv1_stream_ctrl.sv
// Frame sequencer for the conv1 3x3 line buffer: clear it, stream one image at one
// pixel per cycle with no gaps, drain, then count and tag the windows that come back.
module conv1_stream_ctrl #(
  parameter int WIDTH      = 28,
  parameter int HEIGHT     = 28,
  parameter int CLR_CYCLES = 2,
  parameter int DRAIN_MAX  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   img_addr,
  output logic                              img_rd_en,
  input  logic                              img_data,
  output logic                              buf_rst_n,
  output logic                              buf_pixel,
  input  logic                              buf_valid,
  output logic [$clog2(HEIGHT)-1:0]         win_row,
  output logic [$clog2(WIDTH)-1:0]          win_col,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int EXP  = (WIDTH - 2) * (HEIGHT - 2);
  localparam int AW   = $clog2(NPIX);
  localparam int WCW  = $clog2(EXP + 1);
  localparam int CLW  = $clog2(CLR_CYCLES + 1);
  localparam int DW   = $clog2(DRAIN_MAX + 1);
  localparam int CW   = $clog2(WIDTH);

  localparam logic [AW-1:0]  LAST_ADDR  = AW'(NPIX - 1);
  localparam logic [WCW-1:0] EXP_CNT    = WCW'(EXP);
  localparam logic [WCW-1:0] LAST_WIN   = WCW'(EXP - 1);
  localparam logic [CW-1:0]  LAST_COL   = CW'(WIDTH - 3);
  localparam logic [CLW-1:0] CLR_LAST   = CLW'(CLR_CYCLES - 1);
  localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic           timeout;
  logic [CLW-1:0] clr_cnt;
  logic [DW-1:0]  drain_cnt;
  logic [WCW-1:0] win_cnt;
  logic           pix_vld;
  logic           win_take;
  logic           win_full_nx;

  // Windows only count while pixels are in flight, and never beyond a full frame.
  assign win_take    = buf_valid && (state == S_STREAM || state == S_DRAIN) && (win_cnt != EXP_CNT);
  assign win_full_nx = (win_cnt == EXP_CNT) || (win_take && win_cnt == LAST_WIN);

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign buf_pixel = pix_vld & img_data;

  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nx = S_CLEAR;
      S_CLEAR:  if (clr_cnt == CLR_LAST) state_nx = S_STREAM;
      S_STREAM: if (img_addr == LAST_ADDR) state_nx = S_DRAIN;
      S_DRAIN: begin
        if (win_full_nx) begin
          state_nx = S_DONE;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_nx = S_DONE;
          timeout  = 1'b1;
        end
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      img_addr  <= '0;
      img_rd_en <= 1'b0;
      buf_rst_n <= 1'b0;
      pix_vld   <= 1'b0;
      clr_cnt   <= '0;
      drain_cnt <= '0;
      win_cnt   <= '0;
      win_row   <= '0;
      win_col   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      img_rd_en <= (state_nx == S_STREAM);
      pix_vld   <= img_rd_en;
      img_addr  <= (state == S_STREAM && state_nx == S_STREAM) ? img_addr + 1'b1 : '0;
      clr_cnt   <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
      // Release the buffer one cycle into STREAM, exactly when pixel 0 arrives.
      buf_rst_n <= (state == S_STREAM) || (state == S_DRAIN && state_nx == S_DRAIN);

      if (state == S_IDLE && start) begin
        err     <= 1'b0;
        win_cnt <= '0;
        win_row <= '0;
        win_col <= '0;
      end else if (win_take) begin
        win_cnt <= win_cnt + 1'b1;
        // The final window keeps its tag rather than stepping off the image.
        if (win_cnt != LAST_WIN) begin
          if (win_col == LAST_COL) begin
            win_col <= '0;
            win_row <= win_row + 1'b1;
          end else begin
            win_col <= win_col + 1'b1;
          end
        end
      end

      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv1_stream_ctrl.sv
// Bench for conv1_stream_ctrl: image memory and 3x3 buffer models plus a frame-timeline reference.
module tb_conv1_stream_ctrl;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int CLR  = 2;
  localparam int DMAX = 8;
  localparam int N    = W * H;
  localparam int EXP  = (W - 2) * (H - 2);
  localparam int AW   = $clog2(N);
  localparam int RW   = $clog2(H);
  localparam int CW   = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] img_addr;
  logic          img_rd_en;
  logic          img_data = 1'b0;
  logic          buf_rst_n;
  logic          buf_pixel;
  logic          buf_valid = 1'b0;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  conv1_stream_ctrl #(.WIDTH(W), .HEIGHT(H), .CLR_CYCLES(CLR), .DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rst(rst), .start(start),
    .img_addr(img_addr), .img_rd_en(img_rd_en), .img_data(img_data),
    .buf_rst_n(buf_rst_n), .buf_pixel(buf_pixel), .buf_valid(buf_valid),
    .win_row(win_row), .win_col(win_col),
    .busy(busy), .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tot_win = 0;
  int tot_done = 0;
  int tot_addr = 0;
  bit img [0:N-1];
  bit drop_tail = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d cycle=%0d", name, got, want, cyc);
    end
  endtask

  // Synchronous-read image memory; toggles garbage when not read.
  always @(posedge clk) img_data <= img_rd_en ? img[img_addr] : ~img_data;

  // 3x3 window buffer: one pixel per released cycle, window valid the cycle after pixel (r>=2,c>=2).
  int pcnt = 0;
  int wseen = 0;
  always @(posedge clk) begin
    if (!buf_rst_n) begin
      pcnt <= 0; wseen <= 0; buf_valid <= 1'b0;
    end else if (pcnt < N) begin
      if (pcnt / W >= 2 && pcnt % W >= 2) begin
        buf_valid <= !(drop_tail && wseen >= EXP - 5);
        wseen <= wseen + 1;
      end else begin
        buf_valid <= 1'b0;
      end
      pcnt <= pcnt + 1;
    end else begin
      buf_valid <= 1'b0;
    end
  end

  // Reference: position in the frame timeline (e = cycles since start accepted) decides outputs.
  bit m_in = 0, m_done_now = 0, m_err = 0, m_prev_rd = 0;
  int m_e = 0, m_wcnt = 0, m_prev_addr = 0;

  initial begin : compare
    bit e_busy, e_done, e_rd, e_rstn, e_pix;
    int k;
    forever begin
      @(negedge clk);
      cyc++;
      k = m_e - CLR - 1;
      e_busy = 0; e_done = 0; e_rd = 0; e_rstn = 0;
      if (m_in) begin
        e_busy = 1'b1;
        if (m_done_now) e_done = 1'b1;
        else if (m_e > CLR) begin
          if (k < N) begin e_rd = 1'b1; e_rstn = (k >= 1); end
          else e_rstn = 1'b1;
        end
      end
      e_pix = m_prev_rd ? img[m_prev_addr] : 1'b0;
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("img_rd_en", img_rd_en, e_rd);
      chk("buf_rst_n", buf_rst_n, e_rstn);
      chk("buf_pixel", buf_pixel, e_pix);
      chk("err", err, m_err);
      if (e_rd) chk("img_addr", img_addr, k);
      if (buf_valid && m_in && !m_done_now && m_e > CLR && m_wcnt < EXP) begin
        chk("win_row", win_row, m_wcnt / (W - 2));
        chk("win_col", win_col, m_wcnt % (W - 2));
        tot_win++;
      end
      if (done === 1'b1) tot_done++;
      if (img_rd_en === 1'b1) tot_addr++;

      m_prev_rd = e_rd;
      m_prev_addr = e_rd ? k : 0;
      if (rst) begin
        m_in = 0; m_done_now = 0; m_err = 0; m_wcnt = 0; m_prev_rd = 0;
      end else if (!m_in) begin
        if (start) begin m_in = 1; m_e = 1; m_wcnt = 0; m_err = 0; m_done_now = 0; end
      end else if (m_done_now) begin
        m_in = 0; m_done_now = 0;
      end else begin
        if (buf_valid && m_e > CLR && m_wcnt < EXP) m_wcnt++;
        if (k >= N) begin
          if (m_wcnt == EXP) m_done_now = 1;
          else if (k - N + 1 == DMAX) begin m_done_now = 1; m_err = 1; end
        end
        m_e++;
      end
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat = i; break; end
    end
  endtask

  task automatic wait_addr(input int a, output bit found);
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (img_rd_en === 1'b1 && img_addr == AW'(a)) begin found = 1; break; end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin : stim
    int lat, lat2, rise, w0, a0, d0;
    bit found;
    for (int i = 0; i < N; i++) img[i] = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_img_addr", img_addr, 0);
    chk("rst_rd_en", img_rd_en, 0);
    chk("rst_buf_rst_n", buf_rst_n, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);

    // All-ones frame
    @(posedge clk); #1; w0 = tot_win; a0 = tot_addr; d0 = tot_done;
    pulse_start();
    wait_done(lat);
    chk("lat_ones", lat, 789);
    chk("err_ones", err, 0);
    @(posedge clk); #1;
    chk("win_ones", tot_win - w0, 676);
    chk("addr_ones", tot_addr - a0, 784);
    chk("done_ones", tot_done - d0, 1);

    // Checkerboard frame, buffer release lines up with pixel 0
    for (int i = 0; i < N; i++) img[i] = bit'(((i / W) + (i % W)) % 2);
    pulse_start();
    rise = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (buf_rst_n === 1'b1) begin rise = i; break; end
    end
    chk("rise_cb", rise, 4);
    wait_done(lat);
    chk("lat_cb", rise + lat, 789);

    // Buffer drops its last 5 windows: drain timeout
    @(posedge clk); #1; w0 = tot_win; drop_tail = 1'b1;
    pulse_start();
    wait_done(lat);
    chk("lat_timeout", lat, 795);
    chk("err_at_done", err, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", err, 1);
    chk("win_timeout", tot_win - w0, 671);
    drop_tail = 1'b0;
    pulse_start();
    @(negedge clk);
    chk("err_cleared", err, 0);
    wait_done(lat);
    chk("lat_after_timeout", lat + 1, 789);

    // start during STREAM is ignored
    @(posedge clk); #1; w0 = tot_win; a0 = tot_addr; d0 = tot_done;
    pulse_start();
    wait_addr(299, found);
    chk("seen_addr_299", found, 1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(lat);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_after_restart_try", busy, 0);
    chk("done_restart_try", tot_done - d0, 1);
    chk("addr_restart_try", tot_addr - a0, 784);
    chk("win_restart_try", tot_win - w0, 676);

    // Reset mid-stream, then a clean frame
    d0 = tot_done;
    pulse_start();
    wait_addr(399, found);
    chk("seen_addr_399", found, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", img_rd_en, 0);
    chk("abort_buf_rst_n", buf_rst_n, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", tot_done - d0, 0);
    w0 = tot_win;
    pulse_start();
    wait_done(lat);
    chk("lat_after_abort", lat, 789);
    @(posedge clk); #1;
    chk("win_after_abort", tot_win - w0, 676);

    // Back-to-back frames with start held high
    w0 = tot_win;
    start = 1'b1;
    @(posedge clk); #1;
    wait_done(lat);
    chk("lat_b2b_first", lat, 789);
    wait_done(lat2);
    chk("gap_b2b", lat2, 790);
    @(posedge clk); #1 start = 1'b0;
    chk("win_b2b", tot_win - w0, 2 * 676);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_b2b", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
